// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART receiver and transmitter.
//   uart_state_e    : receiver FSM states
//   DATA_BITS       : payload bits per frame (8N1)
//   DEFAULT_MAX_CNT : clocks per bit (5208 at 50 MHz gives 9600 baud)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

  localparam int DATA_BITS       = 8;
  localparam int DEFAULT_MAX_CNT = 5208;

endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for the asynchronous serial line plus a
// falling-edge detector on the synchronized value. All flops reset to 1 so
// that reset never produces a spurious start edge.
//   clk    in  system clock
//   rst    in  synchronous active-high reset
//   rx_i   in  raw asynchronous serial input (idle high)
//   rx_s_o out synchronized line (2-cycle latency)
//   fall_o out high for one cycle when rx_s goes 1 -> 0
module uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic rx_s_o,
  output logic fall_o
);

  logic meta_q;
  logic rx_s_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      rx_s_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      rx_s_q <= meta_q;
      prev_q <= rx_s_q;
    end
  end

  assign rx_s_o = rx_s_q;
  assign fall_o = prev_q & ~rx_s_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. Recovers bytes from the serial line, sampling
// each bit at its middle, and presents them with a one-cycle flag, matching
// the data/flag handshake of the transmitter.
//   clk       in  system clock
//   rst       in  synchronous active-high reset
//   rx        in  asynchronous serial input, idle high
//   data      out last correctly framed byte, held until the next good frame
//   flag      out one-cycle pulse: data updated this cycle
//   frame_err out one-cycle pulse: stop bit sampled low
//   busy      out high whenever the FSM is not IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int MAX_CNT = DEFAULT_MAX_CNT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       flag,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF_CNT = MAX_CNT / 2;
  localparam int CW       = $clog2(MAX_CNT);
  localparam int BW       = $clog2(DATA_BITS);

  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_CNT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_CNT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic rx_s;
  logic rx_fall;

  uart_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .rx_i   (rx),
    .rx_s_o (rx_s),
    .fall_o (rx_fall)
  );

  uart_state_e          state_q;
  logic [CW-1:0]        baud_cnt_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [7:0]           data_q;
  logic                 flag_q;
  logic                 frame_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= 8'h00;
      flag_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      // Both status outputs are pulses; they are only raised for the one
      // cycle following the stop-bit sample.
      flag_q      <= 1'b0;
      frame_err_q <= 1'b0;

      case (state_q)
        IDLE: begin
          baud_cnt_q <= '0;
          if (rx_fall) state_q <= START;
        end

        START: begin
          if (baud_cnt_q == HALF_END) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            // A line already back high at mid start bit was a glitch.
            state_q    <= rx_s ? IDLE : DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (baud_cnt_q == LAST_CNT) begin
            baud_cnt_q <= '0;
            shift_q    <= {rx_s, shift_q[DATA_BITS-1:1]};  // LSB first
            if (bit_cnt_q == LAST_BIT) state_q <= STOP;
            else                       bit_cnt_q <= bit_cnt_q + 1'b1;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        STOP: begin
          if (baud_cnt_q == LAST_CNT) begin
            baud_cnt_q <= '0;
            // Leaving at mid stop bit gives half a bit of slack, so a start
            // edge immediately after the stop bit is still caught.
            if (rx_s) begin
              data_q  <= shift_q;
              flag_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        BREAK: begin
          // A line held low must go high before a new start can be seen.
          baud_cnt_q <= '0;
          if (rx_s) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign data      = data_q;
  assign flag      = flag_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int MAXC = 16;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       flag;
  logic       frame_err;
  logic       busy;

  uart_rx #(.MAX_CNT(MAXC)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .flag      (flag),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int          cycle = 0;
  int          n_flag = 0;
  int          n_ferr = 0;
  int          n_both = 0;
  logic [7:0]  flag_data [0:63];
  int          flag_cyc  [0:63];

  always @(posedge clk) cycle <= cycle + 1;

  // Record every pulse, sampled away from the active edge.
  always @(negedge clk) begin
    if (flag && frame_err) n_both = n_both + 1;
    if (flag) begin
      if (n_flag < 64) begin
        flag_data[n_flag] = data;
        flag_cyc[n_flag]  = cycle;
      end
      $display("rx byte #%0d: data=%02h at cycle %0d", n_flag, data, cycle);
      n_flag = n_flag + 1;
    end
    if (frame_err) begin
      $display("framing error pulse at cycle %0d", cycle);
      n_ferr = n_ferr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Hold the line at v for exactly one bit period.
  task automatic drive_bit(input logic v);
    @(posedge clk);
    #1 rx = v;
    repeat (MAXC - 1) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_v);
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1 rx = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  int base;

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_data", {24'd0, data}, 32'h00);
    check("reset_flag", {31'd0, flag}, 32'd0);
    check("reset_ferr", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    idle(5);

    // Single byte A5.
    send_byte(8'hA5, 1'b1);
    idle(20);
    check("single_count", n_flag, 1);
    check("single_data", {24'd0, flag_data[0]}, 32'hA5);
    check("single_ferr", n_ferr, 0);
    @(negedge clk);
    check("single_busy", {31'd0, busy}, 32'd0);

    // 3-clock glitch from idle.
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("glitch_count", n_flag, 1);
    check("glitch_data", {24'd0, data}, 32'hA5);
    check("glitch_busy", {31'd0, busy}, 32'd0);

    // Framing error: 3C with stop bit low, line held low 40 clocks.
    send_byte(8'h3C, 1'b0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("ferr_count", n_ferr, 1);
    check("ferr_noflag", n_flag, 1);
    check("ferr_data_hold", {24'd0, data}, 32'hA5);
    check("ferr_break_busy", {31'd0, busy}, 32'd1);
    idle(20);
    @(negedge clk);
    check("ferr_recover_busy", {31'd0, busy}, 32'd0);
    send_byte(8'h81, 1'b1);
    idle(20);
    check("after_ferr_count", n_flag, 2);
    check("after_ferr_data", {24'd0, flag_data[1]}, 32'h81);

    // Reset during bit 4 of FF.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_data", {24'd0, data}, 32'h00);
    idle(200);
    check("rst_mid_noflag", n_flag, 2);
    check("rst_mid_noferr", n_ferr, 1);
    send_byte(8'h5A, 1'b1);
    idle(20);
    check("post_rst_count", n_flag, 3);
    check("post_rst_data", {24'd0, flag_data[2]}, 32'h5A);

    // Back-to-back frames, zero idle bits.
    base = n_flag;
    send_byte(8'h01, 1'b1);
    send_byte(8'hFE, 1'b1);
    send_byte(8'h7F, 1'b1);
    idle(30);
    check("b2b_count", n_flag, base + 3);
    check("b2b_data0", {24'd0, flag_data[base]}, 32'h01);
    check("b2b_data1", {24'd0, flag_data[base+1]}, 32'hFE);
    check("b2b_data2", {24'd0, flag_data[base+2]}, 32'h7F);
    check("b2b_gap01", flag_cyc[base+1] - flag_cyc[base], 160);
    check("b2b_gap12", flag_cyc[base+2] - flag_cyc[base+1], 160);
    check("b2b_ferr", n_ferr, 1);

    check("flag_ferr_exclusive", n_both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; counterpart of the team's `tx` block. Same baud scheme: `MAX_CNT` clocks per bit; 5208 at 50 MHz gives 9600 baud.
- Recovers bytes from the serial line and emits each byte with a one-cycle `flag`, matching the `tx` input handshake (`data` + `flag`). A `tx` → `uart_rx` loopback therefore round-trips bytes.
- Sits between the board pin and downstream byte consumers.

Parameters:
- `MAX_CNT`, 5208, clocks per bit period; must be ≥ 4.
- `HALF_CNT`, `MAX_CNT/2`, clocks from the start falling edge to the start mid-bit check (derived; do not override).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input; idle high.
- `data`  out  8  last correctly framed byte; held until the next valid frame.
- `flag`  out  1  one-cycle pulse: `data` updated this cycle.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `busy`  out  1  high whenever state ≠ IDLE.

Behaviour:
- **Reset** (`rst`=1 at a `clk` edge, any state, including mid-frame):
  - state = IDLE, all counters = 0, shift register = 0.
  - `data` = 8'h00, `flag` = 0, `frame_err` = 0, `busy` = 0.
  - Synchronizer flops are set to 1 (idle).
  - A partial frame is discarded; no `flag`.
- **Input conditioning:** 2-flop synchronizer `rx` → `rx_s` (2-cycle latency). Falling-edge detect compares `rx_s` with its previous value.
- **Counters:**
  - `baud_cnt`: width `$clog2(MAX_CNT)`, counts 0..`MAX_CNT`-1 then wraps to 0.
  - `bit_cnt`: 3 bits.
- **FSM:**
  - IDLE: `baud_cnt`=0. On falling edge of `rx_s` → START.
  - START: `baud_cnt` increments.
    - At `baud_cnt`==`HALF_CNT`-1, check `rx_s`.
    - If 0: `baud_cnt`←0, `bit_cnt`←0 → DATA.
    - If 1 (glitch): → IDLE, no outputs.
  - DATA: `baud_cnt` increments. At `baud_cnt`==`MAX_CNT`-1 (mid-bit):
    - `shift` ← {`rx_s`, `shift[7:1]`} (LSB first); `baud_cnt`←0.
    - If `bit_cnt`==7 → STOP, else `bit_cnt`++.
  - STOP: at `baud_cnt`==`MAX_CNT`-1, sample `rx_s`.
    - If 1: `data`←`shift`, `flag`←1 for exactly one cycle → IDLE.
    - If 0: `frame_err`←1 for one cycle, `data` unchanged → BREAK.
  - BREAK: wait until `rx_s`==1 → IDLE. Prevents a held-low line from retriggering.
- **Latency:**
  - `flag` rises in the cycle after the stop-bit mid sample.
  - That is ≈ 9.5 bit periods + 3 clocks after the start falling edge on `rx`.
- **Back-to-back frames:** returning to IDLE at stop mid-bit leaves half a bit of margin, so the next start edge is detected with zero idle bits between frames.
- **Output exclusivity:** `flag` and `frame_err` are never high in the same cycle. `busy` is combinational from state.
- **Mid-frame line changes:** no re-synchronisation; only mid-bit samples matter.

Decomposition:
- Shared package `uart_pkg`:
  - state enum: IDLE, START, DATA, STOP, BREAK.
  - `DATA_BITS`=8.
  - default `MAX_CNT`=5208.
  - The same constants are reused by `tx`.
- One natural sub-module: `uart_sync` (2-flop synchronizer + falling-edge detect, reset to 1). Everything else stays in `uart_rx`.

Test Plan:
- **Single byte:** `MAX_CNT`=16; drive 8'hA5 as 8N1 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) → one `flag` pulse, `data`=8'hA5, `frame_err`=0, `busy` low after the frame.
- **Loopback:** `tx`(`MAX_CNT`=5208) → `uart_rx`(5208); send 8'd0..8'd7 spaced 5208×10 clocks → eight `flag` pulses, `data`=0,1,…,7 in order, no `frame_err`.
- **Glitch rejection:** `MAX_CNT`=16; pulse `rx` low for 3 clocks from idle → stays/returns IDLE, no `flag`, `data` unchanged.
- **Framing error:** `MAX_CNT`=16; send 8'h3C with stop bit 0, then hold `rx` low 40 clocks, then high → one `frame_err` pulse, no `flag`, `data` holds the previous value; after `rx` goes high, next frame 8'h81 → `flag`, `data`=8'h81.
- **Reset mid-frame:** `MAX_CNT`=16; assert `rst` 1 cycle during bit 4 of 8'hFF → `busy`=0, `data`=8'h00 next cycle, no `flag` for the aborted frame; following frame 8'h5A received correctly.
- **Back-to-back:** `MAX_CNT`=16; frames 8'h01, 8'hFE, 8'h7F with zero idle bits → three `flag` pulses exactly 160 clocks apart with correct `data`.
